// File: rtl/visor_uart_rx.sv
// visor_uart_rx: 8N1 debug UART receiver with mid-bit sampling and a small receive buffer.
// Optional feature macro VISOR_UART_RX_FIFO_EN: when defined, the buffer is a FIFO_DEPTH-entry
// circular FIFO; when undefined, it is a single holding register.
`timescale 1ns/1ps

module visor_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_busy,
    output logic       framing_error,
    output logic       overrun,
    input  logic       clear_errors
);

    localparam int unsigned TimerWidth = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(CLKS_PER_BIT - 1);
    localparam logic [TimerWidth-1:0] TimerHalf = TimerWidth'(CLKS_PER_BIT / 2);

    // Reject out-of-range configurations at elaboration time.
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("visor_uart_rx: CLKS_PER_BIT must be in 4..65535");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_fifo_depth
        $error("visor_uart_rx: FIFO_DEPTH must be a power of 2 in 2..16");
    end

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e                  state_q, state_d;
    logic                    rx_meta_q, rxs_q;
    logic [TimerWidth-1:0]   timer_q;
    logic [2:0]              bit_idx_q;
    logic [7:0]              shift_q;
    logic                    framing_error_q, overrun_q;

    logic                    bit_take;
    logic                    push;
    logic                    frame_err_set;
    logic                    pop;
    logic                    full;
    logic                    overrun_set;

    // Two-flop synchroniser; both stages idle high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (!rxs_q) state_d = StStart;
            end
            StStart: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (timer_q == TimerHalf) state_d = rxs_q ? StIdle : StData;
            end
            StData: begin
                if (timer_q == TimerLast && bit_idx_q == 3'd7) state_d = StStop;
            end
            StStop: begin
                if (timer_q == TimerLast) state_d = rxs_q ? StIdle : StWaitHigh;
            end
            StWaitHigh: begin
                // Hold off until a break ends so it yields a single framing error.
                if (rxs_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath strobes.
    always_comb begin
        rx_busy       = 1'b0;
        bit_take      = 1'b0;
        push          = 1'b0;
        frame_err_set = 1'b0;
        unique case (state_q)
            StStart: rx_busy = 1'b1;
            StData: begin
                rx_busy  = 1'b1;
                bit_take = (timer_q == TimerLast);
            end
            StStop: begin
                rx_busy       = 1'b1;
                push          = (timer_q == TimerLast) && rxs_q;
                frame_err_set = (timer_q == TimerLast) && !rxs_q;
            end
            default: ;
        endcase
    end

    // Bit timer, bit index and shift register; the timer restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            if (state_d != state_q || timer_q == TimerLast) begin
                timer_q <= '0;
            end else begin
                timer_q <= timer_q + TimerWidth'(1);
            end
            if (state_q != StData) begin
                bit_idx_q <= '0;
            end else if (bit_take) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if (bit_take) begin
                shift_q[bit_idx_q] <= rxs_q;
            end
        end
    end

    assign pop         = rx_ack && rx_valid;
    // A simultaneous pop frees the slot, so a full buffer only overflows without one.
    assign overrun_set = push && full && !pop;

`ifdef VISOR_UART_RX_FIFO_EN
    localparam int unsigned AddrWidth = $clog2(FIFO_DEPTH);

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [AddrWidth:0] wr_ptr_q, rd_ptr_q;
    logic               store;

    // Extra pointer bit distinguishes full (MSBs differ) from empty (pointers equal).
    assign full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AddrWidth{1'b0}}};
    assign rx_valid = (wr_ptr_q != rd_ptr_q);
    assign rx_data  = mem_q[rd_ptr_q[AddrWidth-1:0]];
    assign store    = push && (!full || pop);

    // Circular FIFO storage and pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (store) begin
                mem_q[wr_ptr_q[AddrWidth-1:0]] <= shift_q;
                wr_ptr_q                       <= wr_ptr_q + (AddrWidth + 1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AddrWidth + 1)'(1);
            end
        end
    end
`else
    logic [7:0] hold_q;
    logic       hold_valid_q;

    assign full     = hold_valid_q;
    assign rx_valid = hold_valid_q;
    assign rx_data  = hold_q;

    // Single holding register; a pop in the push cycle makes room for the new byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (push && (!hold_valid_q || pop)) begin
            hold_q       <= shift_q;
            hold_valid_q <= 1'b1;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end
`endif

    // Sticky error flags; a set event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            if (frame_err_set) begin
                framing_error_q <= 1'b1;
            end else if (clear_errors) begin
                framing_error_q <= 1'b0;
            end
            if (overrun_set) begin
                overrun_q <= 1'b1;
            end else if (clear_errors) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;

endmodule

// File: doc/visor_uart_rx.md
# visor_uart_rx

Serial receiver for the supervisor MCU's debug UART, using 8N1 framing and 16x-free mid-bit sampling. It sits directly upstream of the supervisor's `getchar` path. It deserialises bytes from the host line, buffers them, and presents the current byte plus a receive-busy status bit. Supervisor firmware polls the busy bit to load target program words over the link.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per serial bit (50 MHz / 115200). Legal range is 4..65535.
- `FIFO_DEPTH`, default 4: buffer entries. Must be a power of 2 between 2 and 16. Used only when `VISOR_UART_RX_FIFO_EN` is defined.

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `rxd` in 1: asynchronous serial line, idle high.
- `rx_data` out 8: oldest unread byte.
- `rx_valid` out 1: `rx_data` holds an unread byte.
- `rx_ack` in 1: pop the current byte. Ignored when `rx_valid` is low.
- `rx_busy` out 1: a frame is being received.
- `framing_error` out 1: sticky; a stop bit was sampled low.
- `overrun` out 1: sticky; a byte was dropped because the buffer was full.
- `clear_errors` in 1: clears both sticky flags.

## Operation
- `rxd` passes through a 2-FF synchroniser. Both flops reset to 1. All logic below uses the synchronised signal `rxs`.
- The bit timer counts 0..`CLKS_PER_BIT`-1. Its width is the minimum needed to hold `CLKS_PER_BIT`-1.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: when `rxs`=0, clear the timer and go to START.
- START: when the timer reaches `CLKS_PER_BIT`/2 (integer division):
  - if `rxs`=0, go to DATA with the timer cleared and the bit index at 0;
  - if `rxs`=1, treat it as a glitch and return to IDLE. No flags change.
- DATA: when the timer reaches `CLKS_PER_BIT`-1:
  - sample `rxs` into shift bit[index], LSB first;
  - after index 7, go to STOP.
- STOP: when the timer reaches `CLKS_PER_BIT`-1, sample `rxs`:
  - if 1, push the byte and go to IDLE;
  - if 0, discard the byte, set `framing_error`, and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs`=1, then go to IDLE. This handles a break condition, which yields exactly one framing error.
- `rx_busy` is 1 in START, DATA and STOP, and 0 in IDLE and WAIT_HIGH.
- Buffer behaviour:
  - A push while full drops the new byte and sets `overrun`. Existing contents are unchanged.
  - A push and a pop in the same cycle while full is legal: the pop frees the slot, the byte is stored, and there is no overrun.
  - A push and a pop in the same cycle while empty cannot occur, because the pop requires `rx_valid`.
- Sticky flags:
  - `clear_errors` clears both flags.
  - If a set event and `clear_errors` occur in the same cycle, the set wins.
- Reset mid-frame: return to IDLE and empty the buffer. The remainder of the frame is then resynchronised. A subsequent low data bit may be taken as a start bit, which is accepted behaviour.

## Timing
- Reset values:
  - `rx_data`=0x00
  - `rx_valid`=0
  - `rx_busy`=0
  - `framing_error`=0
  - `overrun`=0
  - state=IDLE, buffer empty
- Input latency: `rx_busy` rises 3 cycles after the falling `rxd` edge is registered (2-cycle synchroniser plus IDLE detect).
- Data visibility: the push happens on the stop-sample cycle. `rx_valid` and `rx_data` update on the next edge, the same edge on which `rx_busy` falls. Firmware that waits for busy then idle therefore always sees valid data.
- Pop: `rx_ack` with `rx_valid`=1 advances `rx_data` to the next entry, or drops `rx_valid`, on the next edge.
- Sustained throughput: back-to-back frames with one stop bit are accepted. IDLE detects the next start bit within 1 cycle of the stop sample.

## Configuration
- `VISOR_UART_RX_FIFO_EN` defined: the buffer is a `FIFO_DEPTH`-entry circular FIFO with wrapping read and write pointers, plus one extra bit to distinguish full from empty.
- `VISOR_UART_RX_FIFO_EN` undefined: the buffer is a single holding register, with full equal to `rx_valid`. `FIFO_DEPTH` is ignored. All push, pop and overrun rules are unchanged with depth 1.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4 with the FIFO enabled, unless stated.
- Single 0x4C frame on `rxd`: `rx_busy` is high for about 152 cycles. `rx_valid` rises on the edge `rx_busy` falls, with `rx_data`=0x4C. `rx_ack` then clears `rx_valid`.
- 2-cycle low glitch on idle `rxd`: `rx_busy` pulses and returns to 0 by mid-start. No byte is pushed and no flags are set.
- Frame 0xA5 with stop bit low, followed by 40 low bit-times: `framing_error`=1 once and no byte is pushed. After `rxd` returns high and a 0x31 frame is sent, `rx_data`=0x31.
- Five frames 0x01..0x05 with no `rx_ack`: `overrun`=1. Popping returns 0x01..0x04, then `rx_valid`=0. `clear_errors` then clears `overrun`.
- FIFO full with `rx_ack` asserted on the 5th push cycle: no overrun, and the reads are 0x01..0x05.
- `reset` asserted mid-DATA of the 2nd frame: all outputs return to reset values on the next edge. A following clean 0x7E frame is received correctly. The single-register build (`VISOR_UART_RX_FIFO_EN` undefined) must also show `overrun` on the 2nd unread frame.
